// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: state encoding,
// active-high segment patterns {a..g}, and the "all dark" output values.
package seg_pkg;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } state_e;

   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h73;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h1F;
   localparam logic [6:0] SEG_C = 7'h4E;
   localparam logic [6:0] SEG_D = 7'h3D;
   localparam logic [6:0] SEG_E = 7'h4F;
   localparam logic [6:0] SEG_F = 7'h47;

   localparam logic [7:0]  SEG_OFF = 8'hFF;
   // Wide enough for the largest supported bank; callers slice to NDIG.
   localparam logic [15:0] AN_OFF  = 16'hFFFF;

endpackage

// File: rtl/seg_hex.sv
// Combinational hex nibble to active-high {a..g} segment pattern.
module seg_hex
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_0;
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scan of NDIG common-anode digits through one decoder,
// with a dark gap between slots and a frame pulse after the last digit.
module seg_scan
   import seg_pkg::*;
#(
   parameter int NDIG  = 8,
   parameter int DWELL = 1000,
   parameter int BLANK = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [$clog2(NDIG)-1:0] wr_idx,
   input  logic [3:0]              wr_data,
   input  logic                    wr_dp,
   input  logic [NDIG-1:0]         en_mask,
   output logic [NDIG-1:0]         o_an,
   output logic [7:0]              o_seg,
   output logic                    o_frame
);

   localparam int IW   = $clog2(NDIG);
   localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NDIG - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            pend_q, pend_d;

   logic [3:0]      nib_q [NDIG];
   logic [3:0]      nib_d [NDIG];
   logic [NDIG-1:0] dp_q, dp_d;

   logic            wr_en_q, wr_en_d;
   logic [IW-1:0]   wr_idx_q, wr_idx_d;
   logic [3:0]      wr_data_q, wr_data_d;
   logic            wr_dp_q, wr_dp_d;

   logic [NDIG-1:0] an_q, an_d;
   logic [7:0]      seg_q, seg_d;
   logic            frame_q, frame_d;

   logic            wr_ok;
   logic [6:0]      hex_seg;

   // Only non-power-of-two banks can address a digit that does not exist.
   if ((1 << IW) > NDIG) begin : g_idx_lim
      assign wr_ok = (wr_idx < IW'(NDIG));
   end else begin : g_idx_full
      assign wr_ok = 1'b1;
   end

   seg_hex u_hex (
      .nib (nib_q[idx_q]),
      .seg (hex_seg)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      pend_d  = 1'b0;
      if (state_q == S_BLANK) begin
         if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
         end
      end else if (cnt_q == DWELL_LAST) begin
         state_d = S_BLANK;
         cnt_d   = '0;
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         pend_d  = (idx_q == LAST_IDX);
      end
   end

   // Writes pass through one capture stage before landing in the buffer.
   always_comb begin
      wr_en_d   = wr_en & wr_ok;
      wr_idx_d  = wr_idx;
      wr_data_d = wr_data;
      wr_dp_d   = wr_dp;
      nib_d     = nib_q;
      dp_d      = dp_q;
      if (wr_en_q) begin
         nib_d[wr_idx_q] = wr_data_q;
         dp_d[wr_idx_q]  = wr_dp_q;
      end
   end

   always_comb begin
      an_d    = AN_OFF[NDIG-1:0];
      seg_d   = SEG_OFF;
      frame_d = pend_q;
      if (state_q == S_SHOW && en_mask[idx_q]) begin
         an_d[idx_q] = 1'b0;
         seg_d       = ~{hex_seg, dp_q[idx_q]};
      end
   end

   // NOTE: the digit buffer is reset because a cleared display is part of the reset state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_BLANK;
         cnt_q     <= '0;
         idx_q     <= '0;
         pend_q    <= 1'b0;
         nib_q     <= '{default: '0};
         dp_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
         wr_dp_q   <= 1'b0;
         an_q      <= AN_OFF[NDIG-1:0];
         seg_q     <= SEG_OFF;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pend_q    <= pend_d;
         nib_q     <= nib_d;
         dp_q      <= dp_d;
         wr_en_q   <= wr_en_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         wr_dp_q   <= wr_dp_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         frame_q   <= frame_d;
      end
   end

   assign o_an    = an_q;
   assign o_seg   = seg_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: two configurations share stimulus; a
// time-based reference model queues expected outputs, monitors pop and compare.
module tb_seg_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_idx = '0;
   logic [3:0]  wr_data = '0;
   logic        wr_dp = 1'b0;
   logic [15:0] en_mask = 16'hFFFF;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] an;
      logic [7:0]  seg;
      logic        fr;
   } exp_t;

   logic [6:0] dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int ND = (g == 0) ? 4 : 6;
      localparam int DW = (g == 0) ? 3 : 2;
      localparam int BL = (g == 0) ? 2 : 1;
      localparam int IW = $clog2(ND);

      logic [ND-1:0] an;
      logic [7:0]    seg;
      logic          fr;
      exp_t          q [$];

      seg_scan #(.NDIG(ND), .DWELL(DW), .BLANK(BL)) dut (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en),
         .wr_idx  (wr_idx[IW-1:0]),
         .wr_data (wr_data),
         .wr_dp   (wr_dp),
         .en_mask (en_mask[ND-1:0]),
         .o_an    (an),
         .o_seg   (seg),
         .o_frame (fr)
      );

      // Reference: slot position follows from the edge count since reset;
      // a write sampled at edge t is visible in outputs from edge t+2.
      initial begin : model
         logic [3:0] mnib [16];
         logic [15:0] mdp;
         bit         pv;
         int         pidx, widx, n, m, s, ph, dg;
         logic [3:0] pnib;
         logic       pdp;
         exp_t       e;
         forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
               foreach (mnib[i]) mnib[i] = 4'h0;
               mdp = '0;
               pv  = 1'b0;
               n   = 0;
               q.delete();
            end else begin
               n++;
               m  = n - 1;
               s  = DW + BL;
               ph = m % s;
               dg = (m / s) % ND;
               e.an  = 16'hFFFF;
               e.seg = 8'hFF;
               if (ph >= BL && en_mask[dg]) begin
                  e.an[dg] = 1'b0;
                  e.seg    = ~{dec_tab[mnib[dg]], mdp[dg]};
               end
               e.fr = (m > 0) && (ph == 0) && (dg == 0);
               q.push_back(e);
               if (pv) begin
                  mnib[pidx] = pnib;
                  mdp[pidx]  = pdp;
               end
               widx = int'(wr_idx) % (1 << IW);
               pv   = wr_en && (widx < ND);
               pidx = widx;
               pnib = wr_data;
               pdp  = wr_dp;
            end
         end
      end

      initial begin : monitor
         exp_t e;
         forever begin
            @(negedge clk);
            check($sformatf("d%0d an onehot", g), 32'($countones(~an) <= 1), 32'd1);
            if (rst) begin
               check($sformatf("d%0d rst an", g), 32'(an), (1 << ND) - 1);
               check($sformatf("d%0d rst seg", g), 32'(seg), 32'hFF);
               check($sformatf("d%0d rst frame", g), 32'(fr), 32'd0);
            end else if (q.size() > 0) begin
               e = q.pop_front();
               check($sformatf("d%0d an", g), 32'(an), 32'(e.an[ND-1:0]));
               check($sformatf("d%0d seg", g), 32'(seg), 32'(e.seg));
               check($sformatf("d%0d frame", g), 32'(fr), 32'(e.fr));
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write(input int idx, input int data, input bit dp);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_idx  = 3'(idx);
      wr_data = 4'(data);
      wr_dp   = dp;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int i;
      cycles(3);
      #2 rst = 1'b0;

      // Blank buffer: digit 0 pattern on every lit slot.
      cycles(25);

      write(0, 4'h1, 1'b0);
      write(1, 4'h5, 1'b0);
      write(2, 4'hA, 1'b1);
      write(3, 4'hF, 1'b0);
      cycles(45);

      en_mask = 16'hAAAA;
      cycles(45);
      en_mask = 16'hFFFF;

      // Rewrite digit 2 while it is lit in the 4-digit bank.
      i = 0;
      while (i < 100 && g_dut[0].an !== 4'hB) begin
         @(negedge clk);
         i++;
      end
      check("wait digit2 lit", 32'(g_dut[0].an), 32'hB);
      wr_en = 1'b1; wr_idx = 3'd2; wr_data = 4'h8; wr_dp = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      cycles(10);

      // Out-of-range indices for the 6-digit bank.
      write(6, 4'h3, 1'b1);
      write(7, 4'h9, 1'b1);
      cycles(30);

      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_idx  = 3'($urandom_range(0, 7));
         wr_data = 4'($urandom);
         wr_dp   = 1'($urandom);
         if (k % 23 == 0) en_mask = 16'($urandom);
      end
      wr_en   = 1'b0;
      en_mask = 16'hFFFF;
      cycles(10);

      // Reset in the middle of digit 3's slot.
      i = 0;
      while (i < 100 && g_dut[0].an !== 4'h7) begin
         @(negedge clk);
         i++;
      end
      check("wait digit3 lit", 32'(g_dut[0].an), 32'h7);
      #2 rst = 1'b1;
      #1;
      check("async rst an0", 32'(g_dut[0].an), 32'hF);
      check("async rst seg0", 32'(g_dut[0].seg), 32'hFF);
      check("async rst fr0", 32'(g_dut[0].fr), 32'd0);
      check("async rst an1", 32'(g_dut[1].an), 32'h3F);
      check("async rst seg1", 32'(g_dut[1].seg), 32'hFF);
      cycles(3);
      #2 rst = 1'b0;
      cycles(45);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
